// File: rtl/high_score_keeper_if.sv
// -----------------------------------------------------------------------------
// high_score_keeper_if
//   Bundles the score-counter inputs and the HUD-facing outputs of
//   high_score_keeper. Clock and reset stay plain ports on the module.
//
//   Signals (direction seen from the keeper, i.e. the slave modport):
//     Units/Tens/Hundreds  in   4  current score digits (BCD)
//     newGame              in   1  start-of-game pulse
//     gameOver             in   1  end of game (level or pulse)
//     gameWon              in   1  win flag, also ends the game
//     hsUnits/hsTens/hsHundreds out 4  stored high score digits
//     newRecord            out  1  set on a record update until next newGame
//     recordBlink          out  1  flashing copy of newRecord
//     busy                 out  1  comparison/update in progress
//
//   master: the score-counter / test side, drives the inputs.
//   slave : the keeper itself.
// -----------------------------------------------------------------------------
interface high_score_keeper_if;
  logic [3:0] Units;
  logic [3:0] Tens;
  logic [3:0] Hundreds;
  logic       newGame;
  logic       gameOver;
  logic       gameWon;
  logic [3:0] hsUnits;
  logic [3:0] hsTens;
  logic [3:0] hsHundreds;
  logic       newRecord;
  logic       recordBlink;
  logic       busy;

  modport master (
    output Units, Tens, Hundreds, newGame, gameOver, gameWon,
    input  hsUnits, hsTens, hsHundreds, newRecord, recordBlink, busy
  );

  modport slave (
    input  Units, Tens, Hundreds, newGame, gameOver, gameWon,
    output hsUnits, hsTens, hsHundreds, newRecord, recordBlink, busy
  );
endinterface

// File: rtl/high_score_keeper.sv
// -----------------------------------------------------------------------------
// high_score_keeper
//   Snapshots the final 3-digit BCD score when a game ends (gameOver or
//   gameWon; a win scores as 999), compares it against the stored high score
//   and replaces the high score only on a strict improvement. A record raises
//   newRecord until the next newGame, and recordBlink flashes it for the HUD.
//
//   Ports:
//     clk    in  system clock, all state on the rising edge
//     reset  in  asynchronous, active-high reset
//     bus    high_score_keeper_if.slave (score inputs, high score / flags out)
//
//   Parameters:
//     BLINK_DIV  clk cycles per recordBlink half-period (>= 2)
//     INIT_HS    high score after reset, {Hundreds,Tens,Units} BCD
//
//   Build option:
//     HS_BLINK_EN  when defined, a blink divider toggles recordBlink every
//                  BLINK_DIV cycles while newRecord is set. When undefined,
//                  recordBlink is a registered copy of newRecord.
//
//   All outputs come straight from registers.
// -----------------------------------------------------------------------------
module high_score_keeper #(
  parameter int          BLINK_DIV = 25_000_000,
  parameter logic [11:0] INIT_HS   = 12'h000
) (
  input  logic               clk,
  input  logic               reset,
  high_score_keeper_if.slave bus
);

  if (BLINK_DIV < 2) begin : g_bad_blink_div
    $error("high_score_keeper: BLINK_DIV must be >= 2");
  end

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_RUN  = 3'd1;
  localparam logic [2:0] S_CMP  = 3'd2;
  localparam logic [2:0] S_UPD  = 3'd3;
  localparam logic [2:0] S_DONE = 3'd4;

  logic [2:0]  r_state;
  logic [11:0] r_snap;
  logic [11:0] r_hs;
  logic        r_new_record;
  logic        r_blink;
  logic        r_busy;

  logic [2:0]  w_state_nxt;
  logic        w_new_record_nxt;
  logic        w_end;
  logic        w_snap_gt;

  assign w_end = bus.gameOver | bus.gameWon;

  // Digit-wise, most significant first. Digits above 9 are compared as raw
  // 4-bit values, so no BCD correction is applied.
  always_comb begin
    // NOTE: every output of a combinational block gets a default up front;
    // a path that leaves it unassigned would infer a latch.
    w_snap_gt = 1'b0;
    if (r_snap[11:8] != r_hs[11:8])
      w_snap_gt = r_snap[11:8] > r_hs[11:8];
    else if (r_snap[7:4] != r_hs[7:4])
      w_snap_gt = r_snap[7:4] > r_hs[7:4];
    else
      w_snap_gt = r_snap[3:0] > r_hs[3:0];
  end

  // Next state and next newRecord. Ending a game takes priority over a
  // simultaneous newGame in S_RUN; newGame during S_CMP/S_UPD is dropped.
  always_comb begin
    w_state_nxt      = r_state;
    w_new_record_nxt = r_new_record;
    case (r_state)
      S_IDLE: if (bus.newGame) w_state_nxt = S_RUN;
      S_RUN:  if (w_end)       w_state_nxt = S_CMP;
      S_CMP:  w_state_nxt = w_snap_gt ? S_UPD : S_DONE;
      S_UPD: begin
        w_state_nxt      = S_DONE;
        w_new_record_nxt = 1'b1;
      end
      S_DONE: begin
        if (bus.newGame) begin
          w_state_nxt      = S_RUN;
          w_new_record_nxt = 1'b0;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state      <= S_IDLE;
      r_snap       <= 12'h000;
      r_hs         <= INIT_HS;
      r_new_record <= 1'b0;
      r_busy       <= 1'b0;
    end else begin
      // NOTE: state registers use non-blocking assignments so every register
      // samples the pre-edge values, independent of statement order.
      r_state      <= w_state_nxt;
      r_new_record <= w_new_record_nxt;
      // busy is registered from the next state so it tracks S_CMP/S_UPD
      // exactly without a combinational decode on the output.
      r_busy       <= (w_state_nxt == S_CMP) || (w_state_nxt == S_UPD);
      if (r_state == S_RUN && w_end)
        r_snap <= bus.gameWon ? 12'h999 : {bus.Hundreds, bus.Tens, bus.Units};
      if (r_state == S_UPD)
        r_hs <= r_snap;
    end
  end

`ifdef HS_BLINK_EN
  localparam int          CW      = $clog2(BLINK_DIV);
  localparam logic [CW-1:0] CNT_MAX = CW'(BLINK_DIV - 1);

  logic [CW-1:0] r_blink_cnt;

  // Driven from the next newRecord value so the blink starts high on the
  // same edge the record is taken and drops on the same edge it clears.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_blink_cnt <= '0;
      r_blink     <= 1'b0;
    end else if (!w_new_record_nxt) begin
      r_blink_cnt <= '0;
      r_blink     <= 1'b0;
    end else if (!r_new_record) begin
      r_blink_cnt <= '0;
      r_blink     <= 1'b1;
    end else if (r_blink_cnt == CNT_MAX) begin
      r_blink_cnt <= '0;
      r_blink     <= ~r_blink;
    end else begin
      r_blink_cnt <= r_blink_cnt + 1'b1;
    end
  end
`else
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_blink <= 1'b0;
    else       r_blink <= w_new_record_nxt;
  end
`endif

  assign bus.hsHundreds  = r_hs[11:8];
  assign bus.hsTens      = r_hs[7:4];
  assign bus.hsUnits     = r_hs[3:0];
  assign bus.newRecord   = r_new_record;
  assign bus.recordBlink = r_blink;
  assign bus.busy        = r_busy;

endmodule
